// File: rtl/pga_config_sched_pkg.sv
// Shared definitions for the PGA configuration scheduler: field widths, FSM encodings,
// the per-channel settings record and its reset value.
package pga_config_sched_pkg;

  localparam int unsigned GainW = 4;
  localparam int unsigned OffW  = 5;
  localparam int unsigned CntW  = 12;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLaunch = 2'd1;
  localparam logic [1:0] StAck    = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  typedef struct packed {
    logic [GainW-1:0] gain;
    logic [OffW-1:0]  offset;
    logic             shdn;
    logic             meas;
  } pga_cfg_t;

  // PGAs come up shut down until the host configures them
  localparam pga_cfg_t CfgRst = '{gain: '0, offset: '0, shdn: 1'b1, meas: 1'b0};

endpackage

// File: rtl/pga_config_sched_sync_2ff.sv
// Two-flop synchronizer for a single slow-clock status line.
module pga_config_sched_sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pga_config_sched.sv
// Per-channel PGA settings shadow plus a round-robin scheduler that feeds pending gain/offset
// updates, one at a time, to the shared serial loader.
module pga_config_sched
  import pga_config_sched_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CHW     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk50,
  input  logic             wb_rst,
  input  logic [CHW-1:0]   wr_ch,
  input  logic             wr_gain_en,
  input  logic             wr_vos_en,
  input  logic [GainW-1:0] wr_gain,
  input  logic [OffW-1:0]  wr_offset,
  input  logic             wr_shdn,
  input  logic             wr_meas,
  input  logic             err_clr,
  input  logic             pga_ready,
  output logic             set_gain,
  output logic             set_vos,
  output logic [GainW-1:0] gain,
  output logic [OffW-1:0]  offset,
  output logic             shdn,
  output logic             meas,
  output logic [N_CH-1:0]  pga_sel,
  output logic             busy,
  output logic             done,
  output logic [CHW-1:0]   done_ch,
  output logic             err
);

  logic rdy_s;

  pga_config_sched_sync_2ff u_rdy_sync (
    .clk_i (clk50),
    .rst_i (wb_rst),
    .d_i   (pga_ready),
    .q_o   (rdy_s)
  );

  pga_cfg_t         sh_q [N_CH];
  pga_cfg_t         sh_d [N_CH];
  logic [N_CH-1:0]  dirty_g_q, dirty_g_d, dirty_v_q, dirty_v_d, pend;
  logic [1:0]       state_q, state_d;
  pga_cfg_t         cfg_q, cfg_d;
  logic [N_CH-1:0]  sel_q, sel_d;
  logic [CHW-1:0]   ch_q, ch_d, rr_q, rr_d, pick;
  logic             vos_q, vos_d, err_q, err_d, timeout;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // First requesting channel at or after ptr, wrapping at N_CH
  function automatic logic [CHW-1:0] rr_pick(input logic [N_CH-1:0] req,
                                             input logic [CHW-1:0]  ptr);
    logic [CHW-1:0] sel;
    logic [CHW-1:0] idx;
    logic           found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = CHW'((32'(ptr) + i) % N_CH);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pend = dirty_g_q | dirty_v_q;

  always_comb begin
    sh_d      = sh_q;
    dirty_g_d = dirty_g_q;
    dirty_v_d = dirty_v_q;
    state_d   = state_q;
    cfg_d     = cfg_q;
    sel_d     = sel_q;
    ch_d      = ch_q;
    vos_d     = vos_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q + 1'b1;
    err_d     = err_q & ~err_clr;
    timeout   = 1'b0;
    pick      = rr_pick(pend, rr_q);

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rdy_s && |pend) begin
          ch_d    = pick;
          cfg_d   = sh_q[pick];
          sel_d   = {{(N_CH-1){1'b0}}, 1'b1} << pick;
          state_d = StLaunch;
          if (dirty_g_q[pick]) begin
            vos_d            = 1'b0;
            dirty_g_d[pick]  = 1'b0;
          end else begin
            vos_d            = 1'b1;
            dirty_v_d[pick]  = 1'b0;
          end
        end
      end
      StLaunch: begin
        if (!rdy_s) begin
          state_d = StAck;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          timeout = 1'b1;
        end
      end
      StAck: begin
        if (rdy_s) begin
          state_d = StDrain;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          timeout = 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        // Chain the offset right behind the gain while the same PGA is still selected
        if (!vos_q && dirty_v_q[ch_q]) begin
          vos_d           = 1'b1;
          dirty_v_d[ch_q] = 1'b0;
          cfg_d           = sh_q[ch_q];
          state_d         = StLaunch;
        end else begin
          rr_d    = (32'(ch_q) == N_CH - 1) ? '0 : ch_q + 1'b1;
          sel_d   = '0;
          state_d = StIdle;
        end
      end
    endcase

    if (timeout) begin
      err_d   = 1'b1;
      sel_d   = '0;
      state_d = StIdle;
    end

    // Host writes come last so a same-cycle set beats the scheduler's clear
    if (wr_gain_en) begin
      sh_d[wr_ch].gain  = wr_gain;
      dirty_g_d[wr_ch]  = 1'b1;
    end
    if (wr_vos_en) begin
      sh_d[wr_ch].offset = wr_offset;
      dirty_v_d[wr_ch]   = 1'b1;
    end
    if (wr_gain_en || wr_vos_en) begin
      sh_d[wr_ch].shdn = wr_shdn;
      sh_d[wr_ch].meas = wr_meas;
    end
  end

  always_ff @(posedge clk50) begin
    if (wb_rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        sh_q[i] <= CfgRst;
      end
      dirty_g_q <= '0;
      dirty_v_q <= '0;
      state_q   <= StIdle;
      cfg_q     <= '0;
      sel_q     <= '0;
      ch_q      <= '0;
      vos_q     <= 1'b0;
      rr_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      dirty_g_q <= dirty_g_d;
      dirty_v_q <= dirty_v_d;
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      sel_q     <= sel_d;
      ch_q      <= ch_d;
      vos_q     <= vos_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign set_gain = (state_q == StLaunch) && !vos_q;
  assign set_vos  = (state_q == StLaunch) && vos_q;
  assign gain     = cfg_q.gain;
  assign offset   = cfg_q.offset;
  assign shdn     = cfg_q.shdn;
  assign meas     = cfg_q.meas;
  assign pga_sel  = sel_q;
  assign busy     = (state_q != StIdle) || |pend;
  assign done     = (state_q == StDrain);
  assign done_ch  = ch_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pga_config_sched.sv
// Scoreboard bench for pga_config_sched: a loader model answers commands, expected commands are
// queued as the host writes and checked as set_gain/set_vos rise.
module tb_pga_config_sched;

  localparam int unsigned NCh  = 4;
  localparam int unsigned Chw  = 2;
  localparam int unsigned Tout = 60;

  logic           clk50, wb_rst;
  logic [Chw-1:0] wr_ch;
  logic           wr_gain_en, wr_vos_en, wr_shdn, wr_meas, err_clr, pga_ready;
  logic [3:0]     wr_gain, gain;
  logic [4:0]     wr_offset, offset;
  logic           set_gain, set_vos, shdn, meas, busy, done, err;
  logic [NCh-1:0] pga_sel;
  logic [Chw-1:0] done_ch;

  pga_config_sched #(
    .N_CH    (NCh),
    .CHW     (Chw),
    .TIMEOUT (Tout)
  ) dut (
    .clk50      (clk50),
    .wb_rst     (wb_rst),
    .wr_ch      (wr_ch),
    .wr_gain_en (wr_gain_en),
    .wr_vos_en  (wr_vos_en),
    .wr_gain    (wr_gain),
    .wr_offset  (wr_offset),
    .wr_shdn    (wr_shdn),
    .wr_meas    (wr_meas),
    .err_clr    (err_clr),
    .pga_ready  (pga_ready),
    .set_gain   (set_gain),
    .set_vos    (set_vos),
    .gain       (gain),
    .offset     (offset),
    .shdn       (shdn),
    .meas       (meas),
    .pga_sel    (pga_sel),
    .busy       (busy),
    .done       (done),
    .done_ch    (done_ch),
    .err        (err)
  );

  typedef struct {
    int ch;
    bit vos;
    int val;
    bit shdn;
    bit meas;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_launch = 0;
  int   n_done   = 0;
  int   last_ch  = 0;
  bit   set_prev = 1'b0;
  bit   ld_hold  = 1'b0;
  bit   ld_stuck = 1'b0;

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic push_exp(input int ch, input bit vos, input int val, input bit sd, input bit ms);
    exp_t e;
    e.ch = ch; e.vos = vos; e.val = val; e.shdn = sd; e.meas = ms;
    sb.push_back(e);
  endtask

  task automatic host_wr(input int ch, input bit ge, input bit ve, input int g, input int o,
                         input bit sd, input bit ms);
    @(posedge clk50); #1;
    wr_ch = Chw'(ch); wr_gain_en = ge; wr_vos_en = ve;
    wr_gain = 4'(g); wr_offset = 5'(o); wr_shdn = sd; wr_meas = ms;
    @(posedge clk50); #1;
    wr_gain_en = 1'b0; wr_vos_en = 1'b0;
  endtask

  // Waits for all queued commands to finish and the block to go idle
  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk50);
      n++;
    end
    check_eq({tag, "_quiet"}, int'(sb.size() == 0 && !busy), 1);
  endtask

  // Waits for a command to rise and then fall, i.e. the FSM is now in ACK
  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    while (!(set_gain || set_vos) && n < budget) begin @(negedge clk50); n++; end
    while ((set_gain || set_vos) && n < budget) begin @(negedge clk50); n++; end
    if (n >= budget) check_eq({tag, "_ack_wait"}, n, 0);
  endtask

  // Loader model: ready drops a few cycles after a command and returns after the shift
  initial begin
    pga_ready = 1'b1;
    forever begin
      @(posedge clk50); #1;
      if (ld_hold) begin
        pga_ready = 1'b0;
      end else if (!ld_stuck && (set_gain || set_vos) && pga_ready) begin
        repeat (3) @(posedge clk50);
        #1 pga_ready = 1'b0;
        repeat (6) @(posedge clk50);
        #1 pga_ready = 1'b1;
      end else begin
        pga_ready = 1'b1;
      end
    end
  end

  always @(negedge clk50) begin
    if (!wb_rst) begin
      if ((set_gain || set_vos) && !set_prev) begin
        n_launch++;
        if (sb.size() == 0) begin
          check_eq("unexpected_cmd", int'(set_gain | set_vos), 0);
        end else begin
          cur = sb.pop_front();
          last_ch = cur.ch;
          check_eq("cmd_kind", set_vos, cur.vos);
          check_eq("cmd_sel", pga_sel, 1 << cur.ch);
          check_eq(cur.vos ? "cmd_offset" : "cmd_gain", cur.vos ? offset : gain, cur.val);
          check_eq("cmd_shdn", shdn, cur.shdn);
          check_eq("cmd_meas", meas, cur.meas);
        end
      end
      if (done) begin
        n_done++;
        check_eq("done_ch", done_ch, last_ch);
      end
    end
    set_prev = set_gain || set_vos;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, bad, dn, hi, n;
    wb_rst = 1'b1; wr_ch = '0; wr_gain_en = 1'b0; wr_vos_en = 1'b0; wr_gain = '0;
    wr_offset = '0; wr_shdn = 1'b0; wr_meas = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk50);
    #1 wb_rst = 1'b0;
    @(negedge clk50);
    check_eq("rst_outputs", {set_gain, set_vos, pga_sel, busy, done, err, shdn, meas},
             '0);
    check_eq("rst_fields", {gain, offset, done_ch}, '0);
    repeat (4) @(negedge clk50);

    // 1: single gain write to ch2, one-cycle scheduling latency
    push_exp(2, 1'b0, 5, 1'b0, 1'b0);
    host_wr(2, 1'b1, 1'b0, 5, 0, 1'b0, 1'b0);
    @(negedge clk50);
    check_eq("lat_idle", set_gain, 0);
    @(negedge clk50);
    check_eq("lat_launch", set_gain, 1);
    wait_quiet("t1", 300);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_done_cnt", n_done, 1);

    // 2: both strobes on ch1 -> gain then offset, pga_sel held throughout
    push_exp(1, 1'b0, 3, 1'b0, 1'b1);
    push_exp(1, 1'b1, 5'h1F, 1'b0, 1'b1);
    host_wr(1, 1'b1, 1'b1, 3, 5'h1F, 1'b0, 1'b1);
    n = 0;
    while (!set_gain && n < 20) begin @(negedge clk50); n++; end
    bad = 0; dn = 0; n = 0;
    while (dn < 2 && n < 300) begin
      if (pga_sel !== 4'b0010) bad++;
      if (done) dn++;
      @(negedge clk50);
      n++;
    end
    check_eq("t2_sel_held", bad, 0);
    check_eq("t2_done_pulses", dn, 2);
    wait_quiet("t2", 100);

    // 3: all four gain-dirty with rr_ptr=2; ch2 rewritten during its launch
    ld_hold = 1'b1;
    repeat (4) @(negedge clk50);
    for (int c = 0; c < 4; c++) host_wr(c, 1'b1, 1'b0, c + 8, 0, 1'b1, 1'b0);
    push_exp(2, 1'b0, 10, 1'b1, 1'b0);
    push_exp(3, 1'b0, 11, 1'b1, 1'b0);
    push_exp(0, 1'b0, 8, 1'b1, 1'b0);
    push_exp(1, 1'b0, 9, 1'b1, 1'b0);
    base = n_launch;
    ld_hold = 1'b0;
    n = 0;
    while (!(set_gain && pga_sel == 4'b0100) && n < 50) begin @(negedge clk50); n++; end
    push_exp(2, 1'b0, 4'hA, 1'b1, 1'b0);
    host_wr(2, 1'b1, 1'b0, 4'hA, 0, 1'b1, 1'b0);
    wait_quiet("t3", 1500);
    check_eq("t3_launches", n_launch - base, 5);

    // 4: loader never answers -> timeout, sticky err, no done
    ld_stuck = 1'b1;
    base = n_done;
    push_exp(0, 1'b0, 6, 1'b0, 1'b0);
    host_wr(0, 1'b1, 1'b0, 6, 0, 1'b0, 1'b0);
    n = 0;
    while (!set_gain && n < 20) begin @(negedge clk50); n++; end
    hi = 0;
    while (set_gain && hi < 300) begin @(negedge clk50); hi++; end
    check_eq("t4_len", int'(hi >= Tout && hi <= Tout + 3), 1);
    check_eq("t4_err", err, 1);
    check_eq("t4_sel", pga_sel, 0);
    check_eq("t4_set", {set_gain, set_vos}, 0);
    ld_stuck = 1'b0;
    repeat (10) @(negedge clk50);
    check_eq("t4_no_done", n_done - base, 0);
    check_eq("t4_err_sticky", err, 1);
    check_eq("t4_no_retry", busy, 0);
    @(posedge clk50); #1 err_clr = 1'b1;
    @(posedge clk50); #1 err_clr = 1'b0;
    @(negedge clk50);
    check_eq("t4_err_clr", err, 0);

    // 5: reset during ACK with three channels still dirty
    ld_hold = 1'b1;
    repeat (4) @(negedge clk50);
    for (int c = 0; c < 4; c++) host_wr(c, 1'b1, 1'b0, c + 1, 0, 1'b0, 1'b0);
    push_exp(3, 1'b0, 4, 1'b0, 1'b0);
    ld_hold = 1'b0;
    wait_ack("t5", 60);
    @(posedge clk50); #1 wb_rst = 1'b1;
    @(posedge clk50); #1 wb_rst = 1'b0;
    sb.delete();
    @(negedge clk50);
    check_eq("t5_rst_outputs", {set_gain, set_vos, pga_sel, busy, done, err}, '0);
    base = n_launch;
    repeat (60) @(negedge clk50);
    check_eq("t5_no_cmd", n_launch - base, 0);
    check_eq("t5_idle", busy, 0);

    // 6: rewrite ch1 while it sits in ACK; outputs hold, then the new value is resent
    push_exp(1, 1'b0, 7, 1'b0, 1'b0);
    host_wr(1, 1'b1, 1'b0, 7, 0, 1'b0, 1'b0);
    wait_ack("t6", 60);
    push_exp(1, 1'b0, 9, 1'b1, 1'b1);
    host_wr(1, 1'b1, 1'b0, 9, 0, 1'b1, 1'b1);
    bad = 0; n = 0;
    while (!done && n < 100) begin
      if (gain !== 4'd7 || shdn !== 1'b0 || meas !== 1'b0) bad++;
      @(negedge clk50);
      n++;
    end
    check_eq("t6_hold_cycles", bad, 0);
    check_eq("t6_drain_gain", gain, 7);
    base = n_done;
    wait_quiet("t6", 400);
    check_eq("t6_resend_done", n_done - base, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
